reloj_ctrl: RTL
===============

Name: reloj_ctrl

Overview:
- Controller that sequences the clock time-counter datapath (seconds/minutes/hours counters).
- Derives the 1 Hz time base from the system clock.
- Debounces the two user push-buttons (mode and increment).
- Runs the RUN / SET_MIN / SET_HOUR mode FSM.
- Issues single-cycle increment/clear strobes to the counters. The datapath owns all modulo wrap; this block never sees counter values.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency; prescaler period in cycles (≥4, even).
- DEB_CYCLES, 1_000_000: cycles a synchronized button level must be stable before it is accepted (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous, bouncy.
- btn_inc  in  1  raw increment button, active-high, asynchronous, bouncy.
- inc_sec  out  1  one-cycle strobe: advance seconds counter.
- inc_min  out  1  one-cycle strobe: advance minutes counter.
- inc_hour  out  1  one-cycle strobe: advance hours counter.
- clr_sec  out  1  one-cycle strobe: zero seconds counter.
- mode  out  2  current mode: 0 RUN, 1 SET_MIN, 2 SET_HOUR (3 unused).
- blink  out  1  display-blank control for the field being set.

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - mode=RUN, prescaler=0, blink=1.
  - inc_sec, inc_min, inc_hour and clr_sec all 0.
  - Debouncer sync flops, counters and accepted levels all 0.
- All outputs are registered.
- Button path, per button:
  - 2-FF synchronizer feeds a debounce counter.
  - Counter increments while the synced level differs from the accepted level and clears when they match.
  - When the counter reaches DEB_CYCLES, the accepted level takes the synced level and the counter clears.
  - A press pulse is one cycle on the accepted level's 0→1 edge. No pulse on release.
  - Any glitch shorter than DEB_CYCLES cycles produces no pulse.
- Prescaler:
  - Width $clog2(CLK_HZ). Counts 0..CLK_HZ-1 and wraps; runs in every mode.
  - tick = (prescaler == CLK_HZ-1).
- FSM on mode press:
  - RUN→SET_MIN, with clr_sec pulsed in the same cycle as the mode update.
  - SET_MIN→SET_HOUR.
  - SET_HOUR→RUN, with the prescaler forced to 0 so the first second after setting is full length.
  - mode==3 is illegal; it recovers to RUN on the next clock.
- Strobes:
  - RUN: inc_sec = registered tick; inc presses ignored.
  - SET_MIN: inc press → inc_min; tick suppressed (no inc_sec).
  - SET_HOUR: inc press → inc_hour; tick suppressed.
- Simultaneous mode press and inc press in the same cycle: the mode transition wins and the inc press is discarded.
- Output exclusivity: at most one of inc_sec/inc_min/inc_hour is high in any cycle. clr_sec never coincides with inc_*.
- blink:
  - 1 in RUN.
  - In SET modes, blink = (prescaler < CLK_HZ/2), i.e. 1 Hz, 50% duty.
- Reset mid-operation: any mode returns to RUN immediately. A strobe in flight is dropped, never stretched.

Optional Feature:
- Macro: RELOJ_CTRL_AUTO_REPEAT_EN.
- Defined: in SET modes, an inc level accepted high for CLK_HZ/2 continuous cycles after its press pulse emits a further inc_min/inc_hour strobe, then one every CLK_HZ/4 cycles until release or mode change. The repeat counter clears on release, on mode change and on reset.
- Undefined: exactly one strobe per press; no repeat logic synthesized.

Decomposition:
- Package reloj_pkg:
  - mode encodings MODE_RUN=2'd0, MODE_SET_MIN=2'd1, MODE_SET_HOUR=2'd2;
  - mode_t typedef;
  - shared with the display mux and the counter datapath.
- Sub-module reloj_debounce (parameter DEB_CYCLES; ports clk, rst_n, raw, level, press). Contains the synchronizer, the debounce counter and the edge detector. Instantiated twice.

Test Plan (CLK_HZ=8, DEB_CYCLES=3):
1. Reset, then 24 idle cycles → mode=0, blink=1, inc_sec pulses exactly 3 times, 8 cycles apart; inc_min, inc_hour, clr_sec stay 0.
2. btn_mode toggled with 1-cycle and 2-cycle glitches → no mode change, no clr_sec. Then held 10 cycles → mode=1 and exactly one clr_sec pulse in the same cycle; inc_sec stops.
3. In SET_MIN, two clean inc presses → exactly 2 inc_min pulses, 0 inc_hour. Mode press → mode=2. Inc press → 1 inc_hour pulse; blink toggles with period 8 cycles.
4. In SET_MIN, mode and inc pressed in the same cycle → mode=2, no inc_min and no inc_hour. Mode press → mode=0; first inc_sec follows exactly 8 cycles after the mode update.
5. rst_n pulsed low mid SET_HOUR while inc held → mode=0 at once, all strobes 0, blink=1. Releasing rst_n with the button still held yields no spurious press until the button is released and pressed again.
6. With RELOJ_CTRL_AUTO_REPEAT_EN, inc held 20 cycles in SET_MIN → pulses at press, +4, +6, +8… cycles. Without the macro → exactly 1 pulse.

Source files
------------

// File: rtl/reloj_pkg.sv
// reloj_pkg: shared definitions for the clock controller, display mux and
// counter datapath.
//   mode_t       : operating mode as driven on reloj_ctrl.mode
//   MODE_W       : width of the mode field
//   is_set_mode(): true for the two time-setting modes
package reloj_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_MIN  = 2'd1,
        MODE_SET_HOUR = 2'd2
    } mode_t;

    function automatic logic is_set_mode(input mode_t m);
        return (m == MODE_SET_MIN) || (m == MODE_SET_HOUR);
    endfunction

endpackage

// File: rtl/reloj_debounce.sv
// reloj_debounce: 2-FF synchronizer, debounce counter and press detector for
// one raw push-button.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   raw   in  raw button level, asynchronous and bouncy
//   level out accepted (debounced) button level
//   press out one-cycle pulse on the accepted 0->1 edge
module reloj_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [1:0]    vld_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    // A press is only reported once the button has been seen released after
    // reset, so a button held through reset never yields a press pulse.
    // vld_q marks the synchronizer as holding real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            press_q <= 1'b0;
            if (vld_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= sync2_q & armed_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/reloj_ctrl.sv
// reloj_ctrl: clock controller. Generates the 1 Hz time base, debounces the
// mode/increment buttons, runs the RUN / SET_MIN / SET_HOUR mode FSM and
// issues single-cycle strobes to the time-counter datapath.
//   clk, rst_n          system clock, asynchronous active-low reset
//   btn_mode, btn_inc   raw push-buttons (active-high, bouncy)
//   inc_sec/min/hour    one-cycle advance strobes
//   clr_sec             one-cycle seconds clear (on entering SET_MIN)
//   mode                current mode (reloj_pkg::mode_t encoding)
//   blink               display-blank control for the field being set
// Build option: RELOJ_CTRL_AUTO_REPEAT_EN enables auto-repeat of a held
// increment button in the set modes.
module reloj_ctrl
    import reloj_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

    logic mode_level, mode_press;
    logic inc_level, inc_press;
    logic unused_levels;

    reloj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    reloj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    assign unused_levels = &{1'b0, mode_level, inc_level};

    mode_t         mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          inc_sec_q, inc_sec_d;
    logic          inc_min_q, inc_min_d;
    logic          inc_hour_q, inc_hour_d;
    logic          clr_sec_q, clr_sec_d;
    logic          blink_q, blink_d;
    logic          tick;
    logic          inc_fire;

`ifdef RELOJ_CTRL_AUTO_REPEAT_EN
    localparam logic [PW-1:0] RPT_FIRST = PW'(CLK_HZ / 2);
    localparam logic [PW-1:0] RPT_NEXT  = PW'(CLK_HZ / 4);

    logic [PW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_first_q, rpt_first_d;
    logic          rpt_fire;

    // rpt_cnt_q counts cycles since the last strobe; zero means idle.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        if (!is_set_mode(mode_q) || mode_press || !inc_level) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else if (inc_press) begin
            rpt_cnt_d   = PW'(1);
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q != '0) begin
            if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = PW'(1);
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    assign inc_fire = inc_press | rpt_fire;
`else
    assign inc_fire = inc_press;
`endif

    assign tick = (pre_q == PRE_LAST);

    // A mode press always takes priority over an increment in the same cycle.
    always_comb begin
        mode_d     = mode_q;
        pre_d      = tick ? '0 : pre_q + 1'b1;
        inc_sec_d  = 1'b0;
        inc_min_d  = 1'b0;
        inc_hour_d = 1'b0;
        clr_sec_d  = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                if (mode_press) begin
                    mode_d    = MODE_SET_MIN;
                    clr_sec_d = 1'b1;
                end else begin
                    inc_sec_d = tick;
                end
            end
            MODE_SET_MIN: begin
                if (mode_press) mode_d = MODE_SET_HOUR;
                else            inc_min_d = inc_fire;
            end
            MODE_SET_HOUR: begin
                if (mode_press) begin
                    mode_d = MODE_RUN;
                    pre_d  = '0;
                end else begin
                    inc_hour_d = inc_fire;
                end
            end
            default: mode_d = MODE_RUN;
        endcase
        blink_d = (mode_d == MODE_RUN) ? 1'b1 : (pre_d < PRE_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_RUN;
            pre_q       <= '0;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hour_q  <= 1'b0;
            clr_sec_q   <= 1'b0;
            blink_q     <= 1'b1;
`ifdef RELOJ_CTRL_AUTO_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            mode_q      <= mode_d;
            pre_q       <= pre_d;
            inc_sec_q   <= inc_sec_d;
            inc_min_q   <= inc_min_d;
            inc_hour_q  <= inc_hour_d;
            clr_sec_q   <= clr_sec_d;
            blink_q     <= blink_d;
`ifdef RELOJ_CTRL_AUTO_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign inc_sec  = inc_sec_q;
    assign inc_min  = inc_min_q;
    assign inc_hour = inc_hour_q;
    assign clr_sec  = clr_sec_q;
    assign mode     = mode_q;
    assign blink    = blink_q;

endmodule
